// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and converts four raw direction
// buttons into one-cycle move pulses with optional hold-to-repeat. Channel
// order everywhere is {up, down, left, right} = bits [3:0].
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               RPT_ON   = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [3:0] btn_raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] stable_v;
    logic [3:0] pulse_v;
    logic       ud_conflict;
    logic       lr_conflict;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        logic             stable;
        logic [CNT_W-1:0] db_cnt;
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] rep_cnt;
        logic [CNT_W-1:0] rep_cnt_nxt;
        logic             pulse;
        logic             pulse_nxt;

        // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
        // disagreeing samples; any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stable <= 1'b0;
                db_cnt <= '0;
            end else if (sync2[ch] != stable) begin
                if (db_cnt >= DB_LAST) begin
                    stable <= ~stable;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= sat_inc(db_cnt);
                end
            end else begin
                db_cnt <= '0;
            end
        end

        // Repeat FSM state, counter and registered pulse.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= ST_IDLE;
                rep_cnt <= '0;
                pulse   <= 1'b0;
            end else begin
                state   <= state_nxt;
                rep_cnt <= rep_cnt_nxt;
                pulse   <= pulse_nxt;
            end
        end

        // Next-state logic; a release always wins over a due pulse.
        always_comb begin
            state_nxt = state;
            case (state)
                ST_IDLE: begin
                    if (stable) state_nxt = ST_DELAY;
                end
                ST_DELAY: begin
                    if (!stable)                           state_nxt = ST_IDLE;
                    else if (RPT_ON && rep_cnt >= RD_LAST) state_nxt = ST_REPEAT;
                end
                ST_REPEAT: begin
                    if (!stable) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Pulse request and counter update for the next cycle.
        always_comb begin
            pulse_nxt   = 1'b0;
            rep_cnt_nxt = rep_cnt;
            case (state)
                ST_IDLE: begin
                    rep_cnt_nxt = '0;
                    if (stable) pulse_nxt = 1'b1;
                end
                ST_DELAY: begin
                    if (!stable) begin
                        rep_cnt_nxt = '0;
                    end else if (RPT_ON && rep_cnt >= RD_LAST) begin
                        pulse_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else if (rep_cnt < RD_LAST) begin
                        rep_cnt_nxt = sat_inc(rep_cnt);
                    end
                end
                ST_REPEAT: begin
                    if (!stable) begin
                        rep_cnt_nxt = '0;
                    end else if (rep_cnt >= RP_LAST) begin
                        pulse_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = sat_inc(rep_cnt);
                    end
                end
                default: rep_cnt_nxt = '0;
            endcase
        end

        assign stable_v[ch] = stable;
        assign pulse_v[ch]  = pulse;
    end

    // Opposing buttons held together cancel each other's pulses; the FSMs
    // keep running underneath, so suppressed pulses are simply dropped.
    assign ud_conflict = stable_v[3] & stable_v[2];
    assign lr_conflict = stable_v[1] & stable_v[0];

    assign up    = pulse_v[3] & ~ud_conflict;
    assign down  = pulse_v[2] & ~ud_conflict;
    assign left  = pulse_v[1] & ~lr_conflict;
    assign right = pulse_v[0] & ~lr_conflict;
    assign held  = stable_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. A second instance has REPEAT_EN=0.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;

    logic       up, down, left, right;
    logic [3:0] held;
    logic       up_n, down_n, left_n, right_n;
    logic [3:0] held_n;

    logic [7:0] obs0;
    logic [7:0] obs1;

    int total = 0;
    int bad = 0;

    assign obs0 = {up, down, left, right, held};
    assign obs1 = {up_n, down_n, left_n, right_n, held_n};

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(1), .CNT_W(25)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .up(up), .down(down), .left(left), .right(right), .held(held)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(0), .CNT_W(25)
    ) dut_norpt (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .up(up_n), .down(down_n), .left(left_n), .right(right_n), .held(held_n)
    );

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn_up = 1'b1;
        btn_right = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            total++;
            if (obs0 !== 8'h00 || obs1 !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold n=%0d got=%h/%h exp=00/00", n, obs0, obs1);
            end
        end
        btn_up = 1'b0;
        btn_right = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            total++;
            if (obs0 !== 8'h00 || obs1 !== 8'h00) begin
                bad++;
                $display("FAIL reset_idle n=%0d got=%h/%h exp=00/00", n, obs0, obs1);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        for (int i = 0; i < 20; i++) begin
            btn_up = (((i / 2) % 2) == 0);
            step();
            total++;
            if (obs0 !== 8'h00) begin
                bad++;
                $display("FAIL bounce_quiet i=%0d got=%h exp=00", i, obs0);
            end
        end
        btn_up = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            step();
            exp = {(n == 6), 3'b000, ((n >= 5 && n <= 13) ? 4'b1000 : 4'b0000)};
            total++;
            if (obs0 !== exp) begin
                bad++;
                $display("FAIL bounce_press n=%0d got=%b exp=%b", n, obs0, exp);
            end
            if (n == 8) btn_up = 1'b0;
        end
        drain(10);
    endtask

    task automatic test_hold();
        logic [7:0] exp;
        logic       rp;
        int         pulses;
        pulses = 0;
        btn_right = 1'b1;
        for (int n = 0; n <= 60; n++) begin
            step();
            rp  = (n == 6) || (n >= 16 && n <= 49 && ((n - 16) % 3) == 0);
            exp = {3'b000, rp, ((n >= 5 && n <= 50) ? 4'b0001 : 4'b0000)};
            total++;
            if (obs0 !== exp) begin
                bad++;
                $display("FAIL hold_repeat n=%0d got=%b exp=%b", n, obs0, exp);
            end
            if (n >= 6 && n <= 45 && right === 1'b1) pulses++;
            if (n == 45) btn_right = 1'b0;
        end
        total++;
        if (pulses !== 11) begin
            bad++;
            $display("FAIL hold_count got=%0d exp=11", pulses);
        end
        drain(10);
    endtask

    task automatic test_glitch();
        btn_left = 1'b1;
        for (int n = 0; n < 18; n++) begin
            step();
            if (n == 2) btn_left = 1'b0;
            total++;
            if (obs0 !== 8'h00 || obs1 !== 8'h00) begin
                bad++;
                $display("FAIL glitch n=%0d got=%h/%h exp=00/00", n, obs0, obs1);
            end
        end
    endtask

    task automatic test_early_release();
        logic [7:0] exp;
        btn_down = 1'b1;
        for (int n = 0; n <= 25; n++) begin
            step();
            exp = {1'b0, (n == 6), 2'b00, ((n >= 5 && n <= 13) ? 4'b0100 : 4'b0000)};
            total++;
            if (obs0 !== exp || obs1 !== exp) begin
                bad++;
                $display("FAIL early_release n=%0d got=%b/%b exp=%b", n, obs0, obs1, exp);
            end
            if (n == 8) btn_down = 1'b0;
        end
        drain(5);
        // Long hold on the instance without repeat: one pulse only.
        btn_down = 1'b1;
        for (int n = 0; n <= 60; n++) begin
            step();
            exp = {1'b0, (n == 6), 2'b00, ((n >= 5 && n <= 51) ? 4'b0100 : 4'b0000)};
            total++;
            if (obs1 !== exp) begin
                bad++;
                $display("FAIL no_repeat n=%0d got=%b exp=%b", n, obs1, exp);
            end
            if (n == 46) btn_down = 1'b0;
        end
        drain(10);
    endtask

    task automatic test_conflict();
        logic [7:0] exp;
        logic [3:0] hexp;
        logic       upx;
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int n = 0; n <= 35; n++) begin
            step();
            hexp = (n < 5) ? 4'b0000 : ((n <= 25) ? 4'b1100 : 4'b1000);
            upx  = (n >= 28) && (((n - 16) % 3) == 0);
            exp  = {upx, 3'b000, hexp};
            total++;
            if (obs0 !== exp) begin
                bad++;
                $display("FAIL conflict n=%0d got=%b exp=%b", n, obs0, exp);
            end
            if (n == 20) btn_down = 1'b0;
        end
        btn_up = 1'b0;
        drain(15);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        logic       upx;
        btn_up = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            step();
            upx = (n == 6) || (n == 16);
            exp = {upx, 3'b000, ((n >= 5) ? 4'b1000 : 4'b0000)};
            total++;
            if (obs0 !== exp) begin
                bad++;
                $display("FAIL pre_reset n=%0d got=%b exp=%b", n, obs0, exp);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs0 !== 8'h00 || obs1 !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got=%h/%h exp=00/00", obs0, obs1);
        end
        for (int n = 0; n < 2; n++) begin
            step();
            total++;
            if (obs0 !== 8'h00) begin
                bad++;
                $display("FAIL reset_low n=%0d got=%h exp=00", n, obs0);
            end
        end
        reset = 1'b1;
        for (int n = 0; n <= 25; n++) begin
            step();
            upx = (n == 6) || (n >= 16 && ((n - 16) % 3) == 0);
            exp = {upx, 3'b000, ((n >= 5) ? 4'b1000 : 4'b0000)};
            total++;
            if (obs0 !== exp) begin
                bad++;
                $display("FAIL post_reset n=%0d got=%b exp=%b", n, obs0, exp);
            end
        end
        btn_up = 1'b0;
        drain(15);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_hold();
        test_glitch();
        test_early_release();
        test_conflict();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
